// File: rtl/spi_ctrl_pkg.sv
// Shared types and defaults for the SPI frame controller.
package spi_ctrl_pkg;

  localparam int DATA_W_DEF = 27;
  localparam int CNT_W_DEF  = 5;

  // IDLE : nothing loaded, or the last load was already read
  // ARMED: a fresh sample sits in the shift register, drdy raised
  // XFER : host has cs_n low and is clocking data out
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    XFER  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_frame_ctrl_sync_edge.sv
// Multi-flop synchronizer for one async level, plus single-cycle rise/fall
// strobes taken against one extra history flop.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist;

  // Shift the raw level through the chain; hist lags the synced level by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      hist   <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist   <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: buffers decimated samples, pulses `load` into the
// external shift register only while cs_n is high, tracks each cs_n frame,
// and flags overruns / wrong-length frames.
// Optional build macro SPI_FRAME_CNT_EN adds frame_cnt[7:0], a count of
// frames that ended with exactly DATA_W sclk falls.
module spi_frame_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              cs_n,
  input  logic              sclk,
  input  logic              clr_flags,
  output logic              load,
  output logic [DATA_W-1:0] data_out,
  output logic              drdy,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err
`ifdef SPI_FRAME_CNT_EN
  ,
  output logic [7:0]        frame_cnt
`endif
);

  state_t            state;
  logic [DATA_W-1:0] smp_buf;
  logic [DATA_W-1:0] pbuf;
  logic              pend;
  logic              ld_req;
  logic [CNT_W-1:0]  bit_cnt;

  logic cs_n_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic frame_ok, ovr_set, ferr_set;

  // cs_n idles high, so its chain resets to 1 to avoid a fake cs_fall.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (cs_n),
    .q    (cs_n_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .q    (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // Only the falling sclk edge advances the bit count.
  logic unused_sclk;
  assign unused_sclk = sclk_s ^ sclk_rise;

  assign frame_ok = (bit_cnt == CNT_W'(DATA_W));
  // A sample landing in the cs_rise cycle is still an XFER arrival, so a
  // pending sample it displaces counts as an overrun too.
  assign ovr_set  = (state == XFER) && sample_valid && pend;
  assign ferr_set = (state == XFER) && cs_rise && !frame_ok;

  // Frame sequencer: buffers samples, requests loads, counts sclk falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      smp_buf  <= '0;
      pbuf     <= '0;
      pend     <= 1'b0;
      ld_req   <= 1'b0;
      bit_cnt  <= '0;
      load     <= 1'b0;
      data_out <= '0;
      drdy     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      load   <= 1'b0;
      ld_req <= 1'b0;
      // A request raised last cycle is issued only while the host is idle;
      // data_out moves together with load so it is valid for the whole pulse.
      if (ld_req && cs_n_s && state != XFER) begin
        load     <= 1'b1;
        data_out <= smp_buf;
        drdy     <= 1'b1;
      end
      case (state)
        IDLE, ARMED: begin
          if (cs_fall) begin
            // From IDLE this is an unsolicited re-read of the last load.
            state   <= XFER;
            busy    <= 1'b1;
            drdy    <= 1'b0;
            bit_cnt <= '0;
            if (sample_valid) begin
              pbuf <= sample_data;
              pend <= 1'b1;
            end
          end else if (sample_valid) begin
            // Host has not started reading: freshest sample replaces the old.
            smp_buf <= sample_data;
            ld_req  <= 1'b1;
            state   <= ARMED;
          end
        end
        XFER: begin
          if (sclk_fall && bit_cnt != '1)
            bit_cnt <= bit_cnt + 1'b1;
          if (sample_valid) begin
            pbuf <= sample_data;
            pend <= 1'b1;
          end
          if (cs_rise) begin
            busy <= 1'b0;
            if (sample_valid || pend) begin
              smp_buf <= sample_valid ? sample_data : pbuf;
              pend    <= 1'b0;
              ld_req  <= 1'b1;
              state   <= ARMED;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flags; a set in the same cycle as clr_flags wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set  | (overrun   & ~clr_flags);
      frame_err <= ferr_set | (frame_err & ~clr_flags);
    end
  end

`ifdef SPI_FRAME_CNT_EN
  logic good_frame;
  assign good_frame = (state == XFER) && cs_rise && frame_ok;

  // Good-frame counter; a good frame coinciding with a clear counts as 1.
  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt <= '0;
    else if (good_frame)
      frame_cnt <= clr_flags ? 8'd1 : frame_cnt + 8'd1;
    else if (clr_flags)
      frame_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Randomized bench for spi_frame_ctrl: a transaction-level host model
// predicts loads, data, drdy/busy and sticky flags for each frame.
module tb_spi_frame_ctrl;

  localparam int DW = 27;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          cs_n = 1'b1;
  logic          sclk = 1'b0;
  logic          clr_flags = 1'b0;
  logic          load, drdy, busy, overrun, frame_err;
  logic [DW-1:0] data_out;
`ifdef SPI_FRAME_CNT_EN
  logic [7:0]    frame_cnt;
  int            m_fcnt = 0;
`endif

  always #5 clk = ~clk;

  spi_frame_ctrl #(.DATA_W(DW), .SYNC_STAGES(SS), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .cs_n         (cs_n),
    .sclk         (sclk),
    .clr_flags    (clr_flags),
    .load         (load),
    .data_out     (data_out),
    .drdy         (drdy),
    .busy         (busy),
    .overrun      (overrun),
    .frame_err    (frame_err)
`ifdef SPI_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  int total = 0, bad = 0;
  int n_load = 0, m_load = 0;
  bit m_ovr = 0, m_ferr = 0;
  logic [DW-1:0] m_dout = '0;

  always @(negedge clk) if (load === 1'b1) n_load++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_ovr"},  32'(overrun),   32'(m_ovr));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, "_nld"},  32'(n_load),    32'(m_load));
    chk({tag, "_dout"}, 32'(data_out),  32'(m_dout));
`ifdef SPI_FRAME_CNT_EN
    chk({tag, "_fcnt"}, 32'(frame_cnt), 32'(m_fcnt));
`endif
  endtask

  // Host-idle sample: expect a load two cycles after the strobe.
  task automatic pre_sample(input logic [DW-1:0] d);
    sample_valid = 1'b1; sample_data = d;
    tick();
    sample_valid = 1'b0;
    tick();
    chk("ld_pulse", 32'(load), 1);
    chk("ld_data", 32'(data_out), 32'(d));
    chk("ld_drdy", 32'(drdy), 1);
    m_load++; m_dout = d;
    repeat (2) tick();
  endtask

  task automatic clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    m_ovr = 0; m_ferr = 0;
`ifdef SPI_FRAME_CNT_EN
    m_fcnt = 0;
`endif
    tick();
    check_idle_state("clr");
  endtask

  // One cs_n frame of nb sclk pulses with k mid-frame samples; optional
  // sample (co) and/or clr_flags in the cs_rise cycle.
  task automatic frame(input int nb, input int k, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [DW-1:0] c,
                       input bit co, input logic [DW-1:0] cd, input bit clr_rise);
    logic [DW-1:0] md[3];
    logic [DW-1:0] last;
    bit pend, ovset, ferrset;
    int j;
    md[0] = a; md[1] = b; md[2] = c;
    pend = 0; last = '0; j = 0;
    repeat (SS + 4) tick();
    cs_n = 1'b0;
    repeat (SS + 3) tick();
    chk("busy_on", 32'(busy), 1);
    chk("drdy_fall", 32'(drdy), 0);
    for (int i = 0; i < nb; i++) begin
      sclk = 1'b1; repeat (2) tick();
      sclk = 1'b0; repeat (2) tick();
      if (j < k && i == 3 + 6 * j) begin
        sample_valid = 1'b1; sample_data = md[j];
        tick();
        sample_valid = 1'b0;
        if (pend) m_ovr = 1;
        pend = 1; last = md[j]; j++;
      end
    end
    repeat (SS + 2) tick();
    cs_n = 1'b1;
    repeat (SS) tick();
    ovset = 0;
    if (co) begin
      sample_valid = 1'b1; sample_data = cd;
      if (pend) ovset = 1;
      pend = 1; last = cd;
    end
    clr_flags = clr_rise;
    tick();
    sample_valid = 1'b0; clr_flags = 1'b0;
    ferrset = (nb != DW);
    if (clr_rise) begin
      m_ovr = ovset; m_ferr = ferrset;
    end else begin
      m_ovr = m_ovr | ovset; m_ferr = m_ferr | ferrset;
    end
`ifdef SPI_FRAME_CNT_EN
    if (clr_rise) m_fcnt = (nb == DW) ? 1 : 0;
    else if (nb == DW) m_fcnt = (m_fcnt + 1) % 256;
`endif
    tick();
    if (pend) begin
      chk("rise_ld", 32'(load), 1);
      chk("rise_data", 32'(data_out), 32'(last));
      chk("rise_drdy", 32'(drdy), 1);
      m_load++; m_dout = last;
    end else begin
      chk("rise_noload", 32'(load), 0);
    end
    chk("busy_off", 32'(busy), 0);
    repeat (2) tick();
    check_idle_state("frame");
  endtask

  logic [DW-1:0] r0, r1, r2, r3;

  initial begin
    repeat (3) tick();
    chk("rst_load", 32'(load), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_drdy", 32'(drdy), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();
    check_idle_state("rst");

    // normal read
    pre_sample(27'h5A5A5A5);
    repeat (10) tick();
    frame(27, 0, '0, '0, '0, 0, '0, 0);
    // replace before read
    pre_sample(27'h1);
    tick();
    pre_sample(27'h2);
    frame(27, 0, '0, '0, '0, 0, '0, 0);
    // mid-frame arrivals: overrun, freshest loaded at cs_rise
    frame(27, 3, 27'hA, 27'hB, 27'hC, 0, '0, 0);
    clr();
    // short then long frame, clear coinciding with the second end
    frame(20, 0, '0, '0, '0, 0, '0, 0);
    frame(30, 0, '0, '0, '0, 0, '0, 1);
    clr();
    // coincident arrival beats pending 7; pend then empty
    frame(27, 1, 27'h7, '0, '0, 1, 27'h1234567, 0);
    frame(27, 0, '0, '0, '0, 0, '0, 0);
    clr();

    // reset mid-frame with a pending sample
    pre_sample(27'h3C3C3C3);
    repeat (SS + 4) tick();
    cs_n = 1'b0;
    repeat (SS + 3) tick();
    repeat (5) begin sclk = 1'b1; repeat (2) tick(); sclk = 1'b0; repeat (2) tick(); end
    sample_valid = 1'b1; sample_data = 27'h0F0F0F0;
    tick();
    sample_valid = 1'b0;
    tick();
    rst = 1'b1; cs_n = 1'b1;
    tick();
    rst = 1'b0;
    m_ovr = 0; m_ferr = 0; m_dout = '0;
`ifdef SPI_FRAME_CNT_EN
    m_fcnt = 0;
`endif
    chk("mrst_load", 32'(load), 0);
    chk("mrst_drdy", 32'(drdy), 0);
    chk("mrst_busy", 32'(busy), 0);
    repeat (10) tick();
    check_idle_state("mrst");
    chk("mrst_drdy2", 32'(drdy), 0);
    pre_sample(27'h00000F1);
    repeat (3) frame(27, 0, '0, '0, '0, 0, '0, 0);

    // randomized frames
    for (int it = 0; it < 30; it++) begin
      int npre, nb, k;
      npre = int'($urandom_range(0, 2));
      for (int p = 0; p < npre; p++) pre_sample(DW'($urandom));
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(18, 31)) : DW;
      k  = int'($urandom_range(0, 3));
      r0 = DW'($urandom); r1 = DW'($urandom); r2 = DW'($urandom); r3 = DW'($urandom);
      frame(nb, k, r0, r1, r2, $urandom_range(0, 3) == 0, r3, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) clr();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
